// File: rtl/sample_framer_pkg.sv
// rtl/sample_framer_pkg.sv - shared state encoding and sizing helpers for the sample framer
package sample_framer_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    HI    = 2'd1,
    LO    = 2'd2,
    DRAIN = 2'd3
  } framer_state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  localparam int         DEFAULT_NUM_UNITS = 4;

  // Index width for a buffer of 'units' words; never narrower than one bit.
  function automatic int word_idx_width(input int units);
    return (units > 1) ? $clog2(units) : 1;
  endfunction

  localparam int WORD_IDX_W = word_idx_width(DEFAULT_NUM_UNITS);

endpackage

// File: rtl/sample_framer_timeout.sv
// rtl/sample_framer_timeout.sv - loadable idle counter with terminal-count outputs
module frame_timeout_counter #(
  parameter int LIMIT = 1000,
  parameter int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             terminal,
  output logic             terminal_next
);

  localparam logic [CNT_W-1:0] TC    = CNT_W'(LIMIT - 1);
  localparam logic [CNT_W-1:0] TC_M1 = CNT_W'(LIMIT - 2);

  logic [CNT_W-1:0] count;

  // Idle counter: clear wins, then load, then count up and hold at terminal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != TC)) begin
      count <= count + CNT_W'(1);
    end
  end

  // terminal_next lets the owner register a pulse that lines up with terminal.
  assign terminal      = (count == TC);
  assign terminal_next = enable && !clear && !load && (count == TC_M1);

endmodule

// File: rtl/sample_framer.sv
// rtl/sample_framer.sv - sync hunt, word assembly into a frame buffer, burst drain of whole frames
module sample_framer
  import sample_framer_pkg::*;
#(
  parameter int         NUM_UNITS      = DEFAULT_NUM_UNITS,
  parameter int         DATA_WIDTH     = 16,
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic [DATA_WIDTH-1:0] sample_out,
  output logic                  write_sample_out,
  output logic                  frame_done,
  output logic                  frame_error,
  output logic                  overrun,
  output logic [7:0]            error_count
);

  localparam int               IDX_W = word_idx_width(NUM_UNITS);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_UNITS - 1);

  framer_state_t         state, state_next;
  logic [IDX_W-1:0]      word_idx, word_idx_next;
  logic [IDX_W-1:0]      rd_idx, rd_idx_next, rd_idx_inc;
  logic [7:0]            hi_q, hi_next;
  logic [DATA_WIDTH-1:0] frame_buf [NUM_UNITS];
  logic [DATA_WIDTH-1:0] sample_next;
  logic                  write_next, done_next, buf_we;
  logic                  accept, in_frame, timeout, timeout_next;

  assign byte_ready = (state != DRAIN);
  assign accept     = byte_valid && byte_ready;
  assign in_frame   = (state == HI) || (state == LO);
  assign rd_idx_inc = rd_idx + IDX_W'(1);

  frame_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (!in_frame || accept),
    .enable        (in_frame),
    .load          (1'b0),
    .load_value    ('0),
    .terminal      (timeout),
    .terminal_next (timeout_next)
  );

  // Next-state decode; write strobe and word are computed one cycle ahead so the outputs stay registered.
  always_comb begin
    state_next    = state;
    word_idx_next = word_idx;
    rd_idx_next   = rd_idx;
    hi_next       = hi_q;
    buf_we        = 1'b0;
    write_next    = 1'b0;
    done_next     = 1'b0;
    sample_next   = sample_out;
    case (state)
      HUNT: begin
        if (accept && (byte_in == SYNC_BYTE)) begin
          state_next    = HI;
          word_idx_next = '0;
        end
      end
      HI: begin
        if (timeout) begin
          state_next = HUNT;
        end else if (accept) begin
          hi_next    = byte_in;
          state_next = LO;
        end
      end
      LO: begin
        if (timeout) begin
          state_next = HUNT;
        end else if (accept) begin
          buf_we = 1'b1;
          if (word_idx == LAST) begin
            state_next  = DRAIN;
            rd_idx_next = '0;
            write_next  = 1'b1;
            done_next   = (NUM_UNITS == 1);
            sample_next = (NUM_UNITS == 1) ? {hi_q, byte_in} : frame_buf[0];
          end else begin
            word_idx_next = word_idx + IDX_W'(1);
            state_next    = HI;
          end
        end
      end
      DRAIN: begin
        if (rd_idx == LAST) begin
          state_next = HUNT;
        end else begin
          rd_idx_next = rd_idx_inc;
          write_next  = 1'b1;
          done_next   = (rd_idx_inc == LAST);
          sample_next = frame_buf[rd_idx_inc];
        end
      end
      default: state_next = HUNT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
    end else begin
      state <= state_next;
    end
  end

  // Indices, held high byte and registered outputs; reset kills any drain in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_idx         <= '0;
      rd_idx           <= '0;
      hi_q             <= '0;
      sample_out       <= '0;
      write_sample_out <= 1'b0;
      frame_done       <= 1'b0;
      frame_error      <= 1'b0;
      overrun          <= 1'b0;
      error_count      <= '0;
    end else begin
      word_idx         <= word_idx_next;
      rd_idx           <= rd_idx_next;
      hi_q             <= hi_next;
      sample_out       <= sample_next;
      write_sample_out <= write_next;
      frame_done       <= done_next;
      frame_error      <= timeout_next;
      if (byte_valid && !byte_ready) begin
        overrun <= 1'b1;
      end
      if (timeout_next && (error_count != 8'hFF)) begin
        error_count <= error_count + 8'd1;
      end
    end
  end

  // Frame buffer: contents only matter once a full frame has been captured.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      frame_buf[word_idx] <= {hi_q, byte_in};
    end
  end

endmodule

// File: tb/tb_sample_framer.sv
// tb/tb_sample_framer.sv - self-checking bench for sample_framer
module tb_sample_framer;

  localparam int N = 4;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [15:0] sample_out;
  logic        write_sample_out, frame_done, frame_error, overrun;
  logic [7:0]  error_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  sample_framer #(
    .NUM_UNITS      (N),
    .DATA_WIDTH     (16),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .byte_in          (byte_in),
    .byte_valid       (byte_valid),
    .byte_ready       (byte_ready),
    .sample_out       (sample_out),
    .write_sample_out (write_sample_out),
    .frame_done       (frame_done),
    .frame_error      (frame_error),
    .overrun          (overrun),
    .error_count      (error_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Behavioural model: frames of bytes become queued words, emitted one per cycle after completion.
  logic [7:0]  fb[$];
  logic [15:0] pend[$];
  bit          in_frame = 0;
  int          idle_n = 0;
  bit          m_ready = 1;
  logic [15:0] e_sample = 16'h0;
  bit          e_write = 0, e_done = 0, e_err = 0, e_ovr = 0;
  int          e_cnt = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      fb.delete(); pend.delete();
      in_frame = 0; idle_n = 0; m_ready = 1;
      e_sample = 16'h0; e_write = 0; e_done = 0; e_err = 0; e_ovr = 0; e_cnt = 0;
    end else begin
      e_err = 0;
      if (byte_valid && !m_ready) e_ovr = 1;
      if (byte_valid && m_ready) begin
        idle_n = 0;
        if (!in_frame) begin
          if (byte_in == 8'hA5) begin
            in_frame = 1;
            fb.delete();
          end
        end else begin
          fb.push_back(byte_in);
          if (fb.size() == 2 * N) begin
            for (int i = 0; i < N; i++) pend.push_back({fb[2*i], fb[2*i+1]});
            in_frame = 0;
          end
        end
      end else if (in_frame) begin
        idle_n++;
        if (idle_n == T - 1) begin
          e_err = 1;
          if (e_cnt < 255) e_cnt++;
          in_frame = 0;
        end
      end
      if (pend.size() > 0) begin
        e_sample = pend.pop_front();
        e_write  = 1;
        e_done   = (pend.size() == 0);
        m_ready  = 0;
      end else begin
        e_write = 0;
        e_done  = 0;
        m_ready = 1;
      end
    end
  end

  // Observation log for the hand-computed expectations.
  logic [15:0] wlog[$];
  int          rdy_low = 0;
  int          done_cnt = 0;
  logic [15:0] done_word = 16'h0;
  int          err_cyc = -1;

  // Cycle-by-cycle comparison against the model, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    chk("byte_ready", byte_ready, m_ready);
    chk("write_sample_out", write_sample_out, e_write);
    chk("frame_done", frame_done, e_done);
    chk("frame_error", frame_error, e_err);
    chk("overrun", overrun, e_ovr);
    chk("error_count", error_count, e_cnt);
    if (e_write) chk("sample_out", sample_out, e_sample);
    if (write_sample_out) wlog.push_back(sample_out);
    if (!byte_ready) rdy_low++;
    if (frame_done) begin
      done_cnt++;
      done_word = sample_out;
    end
    if (frame_error) err_cyc = cyc;
  end

  logic [7:0]  tx[$];
  logic [15:0] want_q[$];

  task automatic send_all();
    foreach (tx[i]) begin
      @(negedge clk);
      byte_valid = 1'b1;
      byte_in    = tx[i];
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      byte_valid = 1'b0;
    end
  endtask

  task automatic clear_log();
    wlog.delete();
    rdy_low  = 0;
    done_cnt = 0;
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_nwrites"}, wlog.size(), want_q.size());
    foreach (want_q[i]) begin
      if (i < wlog.size()) chk({tag, "_word"}, wlog[i], want_q[i]);
    end
  endtask

  initial begin
    int last_cyc;
    int has77;

    repeat (3) @(negedge clk);
    chk("rst_byte_ready", byte_ready, 1);
    chk("rst_write", write_sample_out, 0);
    chk("rst_sample", sample_out, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_error", frame_error, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_err_cnt", error_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    clear_log();
    tx = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    send_all();
    idle(N + 3);
    want_q = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    check_log("clean");
    chk("clean_ready_low", rdy_low, 4);
    chk("clean_done_cnt", done_cnt, 1);
    chk("clean_done_word", done_word, 16'hDEF0);

    clear_log();
    tx = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_all();
    idle(N + 3);
    want_q = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
    check_log("garbage");
    chk("garbage_err_cnt", error_count, 0);

    clear_log();
    tx = '{8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_all();
    idle(N + 3);
    want_q = '{16'hA5A5, 16'h0001, 16'h0203, 16'h0405};
    check_log("sync_in_data");

    clear_log();
    err_cyc = -1;
    tx = '{8'hA5, 8'h11, 8'h22, 8'h33};
    send_all();
    last_cyc = cyc;
    idle(T + 6);
    chk("timeout_latency", err_cyc - last_cyc, T);
    chk("timeout_nwrites", wlog.size(), 0);
    chk("timeout_err_cnt", error_count, 1);
    tx = '{8'hA5, 8'h21, 8'h43, 8'h65, 8'h87, 8'hA9, 8'hCB, 8'hED, 8'h0F};
    send_all();
    idle(N + 3);
    want_q = '{16'h2143, 16'h6587, 16'hA9CB, 16'hED0F};
    check_log("after_timeout");

    clear_log();
    tx = '{8'hA5, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC8,
           8'h77, 8'h77, 8'h77, 8'h77, 8'h77, 8'h77};
    send_all();
    idle(3);
    chk("overrun_set", overrun, 1);
    tx = '{8'hA5, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5, 8'hD6, 8'hD7, 8'hD8};
    send_all();
    idle(N + 3);
    want_q = '{16'hC1C2, 16'hC3C4, 16'hC5C6, 16'hC7C8, 16'hD1D2, 16'hD3D4, 16'hD5D6, 16'hD7D8};
    check_log("overrun");
    has77 = 0;
    foreach (wlog[i]) if (wlog[i][15:8] == 8'h77 || wlog[i][7:0] == 8'h77) has77++;
    chk("overrun_no_dropped_byte", has77, 0);
    chk("overrun_sticky", overrun, 1);

    clear_log();
    tx = '{8'hA5, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5, 8'hE6, 8'hE7, 8'hE8};
    send_all();
    @(negedge clk);
    byte_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_write", write_sample_out, 0);
    chk("midrst_sample", sample_out, 0);
    chk("midrst_done", frame_done, 0);
    chk("midrst_overrun", overrun, 0);
    chk("midrst_err_cnt", error_count, 0);
    chk("midrst_byte_ready", byte_ready, 1);
    chk("midrst_writes_before", wlog.size(), 2);
    idle(3);
    @(negedge clk);
    rst_n = 1'b1;
    idle(6);
    chk("midrst_no_more_writes", wlog.size(), 2);
    clear_log();
    tx = '{8'hA5, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    send_all();
    idle(N + 3);
    want_q = '{16'h1020, 16'h3040, 16'h5060, 16'h7080};
    check_log("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
